parity_frame_ctrl: RTL

Arbitrates and sequences up to NUM_REQ requesters onto one shared bit-serial parity engine. Each requester offers a WORD_W-bit word. The controller grants requesters round-robin, shifts the granted word LSB-first through the serial XOR accumulator, one bit per clock, and returns the parity bit tagged with the requester ID. It sits between the peripheral data sources and the serial parity datapath, and owns that datapath's frame counting and clearing.

---
 rtl/parity_pkg.sv | 26 ++
 rtl/parity_serial_core.sv | 39 +++
 rtl/parity_frame_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/parity_pkg.sv
// Shared types, defaults and the round-robin pick helper for the parity frame controller.
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WORD_W  = 32;
    localparam int MAX_REQ     = 8;

    // First valid requester at or above ptr, wrapping at n; returns ptr when none is valid.
    function automatic int rr_pick(input logic [MAX_REQ-1:0] valid, input int ptr, input int n);
        int idx;
        rr_pick = ptr;
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            if (i < n) begin
                idx = (ptr + i) % n;
                if (valid[idx[2:0]]) rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/parity_serial_core.sv
// Bit-serial parity datapath: LSB-first shift register, XOR accumulator and frame bit counter.
module parity_serial_core #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst_p,
    input  logic              load,
    input  logic              enable,
    input  logic [WORD_W-1:0] data,
    output logic              acc,
    output logic              last
);
    localparam int CNT_W = $clog2(WORD_W);

    logic [WORD_W-1:0] r_shreg;
    logic              r_acc;
    logic [CNT_W-1:0]  r_cnt;

    assign acc  = r_acc;
    assign last = (r_cnt == CNT_W'(WORD_W - 1));

    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            r_shreg <= '0;
            r_acc   <= 1'b0;
            r_cnt   <= '0;
        end else if (load) begin
            r_shreg <= data;
            r_acc   <= 1'b0;
            r_cnt   <= '0;
        end else if (enable) begin
            r_acc   <= r_acc ^ r_shreg[0];
            r_shreg <= r_shreg >> 1;
            // Counter saturates on the final bit so it never exceeds WORD_W-1.
            if (!last) r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/parity_frame_ctrl.sv
// Round-robin arbiter and frame sequencer in front of a shared serial parity engine.
// Build option: define PARITY_ODD_EN for odd parity (result is the inverted accumulator).
module parity_frame_ctrl
    import parity_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WORD_W  = DEF_WORD_W
) (
    input  logic                       clk,
    input  logic                       rst_p,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WORD_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic                       res_parity,
    output logic [$clog2(NUM_REQ)-1:0] res_id,
    output logic                       busy,
    output state_t                     dbg_state
);
    localparam int ID_W = $clog2(NUM_REQ);

    // Handshakes: a transfer happens on any rising edge where valid and ready are both high;
    // req_ready is only ever raised in IDLE, res_valid only in DONE.

    state_t            r_state;
    state_t            w_next;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [ID_W-1:0]   r_res_id;
    logic [ID_W-1:0]   w_winner;
    int                w_pick;
    logic              w_any;
    logic              w_load;
    logic              w_enable;
    logic              w_acc;
    logic              w_last;
    logic              w_parity;
    logic [WORD_W-1:0] w_word;

    assign w_any    = |req_valid;
    assign w_pick   = rr_pick(MAX_REQ'(req_valid), int'(r_rr_ptr), NUM_REQ);
    assign w_winner = ID_W'(w_pick);
    assign w_word   = req_data[w_winner*WORD_W +: WORD_W];

    always_comb begin
        w_next    = r_state;
        req_ready = '0;
        w_load    = 1'b0;
        w_enable  = 1'b0;
        case (r_state)
            IDLE: begin
                // Gated by reset so no accept strobe is shown while reset is held.
                if (w_any && !rst_p) begin
                    req_ready = NUM_REQ'(1) << w_winner;
                    w_load    = 1'b1;
                    w_next    = SHIFT;
                end
            end
            SHIFT: begin
                w_enable = 1'b1;
                if (w_last) w_next = DONE;
            end
            DONE: begin
                if (res_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
            r_res_id <= '0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_res_id <= w_winner;
                r_rr_ptr <= (w_winner == ID_W'(NUM_REQ - 1)) ? '0 : w_winner + ID_W'(1);
            end
        end
    end

    parity_serial_core #(.WORD_W(WORD_W)) u_core (
        .clk    (clk),
        .rst_p  (rst_p),
        .load   (w_load),
        .enable (w_enable),
        .data   (w_word),
        .acc    (w_acc),
        .last   (w_last)
    );

`ifdef PARITY_ODD_EN
    assign w_parity = ~w_acc;
`else
    assign w_parity = w_acc;
`endif

    assign res_valid  = (r_state == DONE);
    assign res_parity = res_valid & w_parity;
    assign res_id     = r_res_id;
    assign busy       = (r_state != IDLE);
    assign dbg_state  = r_state;

endmodule
